dcache_miss_ctrl: RTL and testbench
===================================

Name: dcache_miss_ctrl

Overview:
- Miss/refill controller downstream of the direct-mapped, one-word-line data cache lookup in the pipelined RISC-V core.
- Consumes the cache's hit indication for MEM-stage loads/stores.
- On a load miss: stalls the pipeline, fetches the word from main memory over a valid/ready request plus valid response handshake, then writes the line back into the cache array.
- Stores are write-through, no-allocate; a store that hits also updates the cached word.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width
- INDEX_BITS, 3, cache index width (8 lines); offset fixed at 2 bits
- TAG_BITS, ADDR_WIDTH-INDEX_BITS-2 (27), tag width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req_valid  in  1  MEM-stage memory access present
- cpu_req_we  in  1  1 = store, 0 = load
- cpu_req_addr  in  ADDR_WIDTH  byte address
- cpu_req_wdata  in  DATA_WIDTH  store data
- cache_hit  in  1  lookup result for cpu_req_addr
- stall  out  1  freeze pipeline; CPU holds request stable while high
- rdata_valid  out  1  refill data returned to pipeline this cycle
- rdata  out  DATA_WIDTH  refill data
- fill_en  out  1  write cache line this cycle
- fill_index  out  INDEX_BITS  line index
- fill_tag  out  TAG_BITS  tag to write; valid bit is set by the cache on fill_en
- fill_data  out  DATA_WIDTH  line data
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  request is a write
- mem_req_addr  out  ADDR_WIDTH  word address; bits [1:0] are forced to 0
- mem_req_wdata  out  DATA_WIDTH  write data
- mem_resp_valid  in  1  read data valid (one cycle)
- mem_resp_data  in  DATA_WIDTH  read data

Behaviour:
- Reset (async, rst_n = 0):
  - State goes to IDLE.
  - All outputs, address/data registers and the captured-hit flag are cleared to 0.
- States: IDLE, RD_REQ, RD_WAIT, FILL, WR_REQ.
- IDLE:
  - Load hit: stall = 0; no action.
  - Load miss: stall = 1 combinationally. Capture address. Next state RD_REQ.
  - Store (hit or miss): stall = 1. Capture address, data and cache_hit. Next state WR_REQ.
  - cpu_req_valid = 0: idle.
- RD_REQ:
  - mem_req_valid = 1, mem_req_we = 0, stall = 1.
  - Request is held stable until mem_req_ready is sampled high, then RD_WAIT.
- RD_WAIT:
  - stall = 1. On mem_req_valid... none; on mem_resp_valid: register the data and go to FILL.
  - Response may arrive any number of cycles later; there is no timeout.
- FILL (exactly 1 cycle):
  - fill_en = 1 with index = addr[INDEX_BITS+1:2], tag = addr[ADDR_WIDTH-1:INDEX_BITS+2], data = registered word.
  - rdata_valid = 1, rdata = same word, stall = 0 (pipeline advances with rdata). Next state IDLE.
- WR_REQ:
  - mem_req_valid = 1, mem_req_we = 1, wdata = captured data, stall = !mem_req_ready.
  - Handshake cycle: if the captured hit is set, fill_en = 1 with the captured index/tag and wdata. Next state IDLE.
- Latency:
  - Load miss with ready = 1 and a next-cycle response: 3 stall cycles (IDLE, RD_REQ, RD_WAIT), data delivered in cycle 4.
  - Store with ready = 1: 1 stall cycle (IDLE), accepted in cycle 2.
- Boundaries:
  - mem_resp_valid outside RD_WAIT is ignored, including a stale response after a mid-operation reset.
  - mem_req_ready outside the request states is ignored.
  - At most one outstanding memory transaction.
  - Back-to-back misses to the same index: the second is re-looked-up after FILL, so it hits.
  - Address bits [1:0] are never forwarded to memory.

Optional Feature:
- Macro: DCACHE_WRITE_BUFFER_EN.
- With the macro: one-entry posted write buffer.
  - A store in IDLE with the buffer empty: captured into the buffer, stall = 0, fill_en same cycle if hit.
  - The buffer drains through WR_REQ whenever the FSM would otherwise be idle.
  - A store with the buffer full stalls until the buffer drains.
  - A load miss first drains the buffer (added state DRAIN) before RD_REQ, preserving memory order.
- Without the macro: the blocking WR_REQ path exactly as above; no DRAIN state.

Decomposition:
- Shared package dcache_pkg:
  - State enum type.
  - INDEX_BITS, OFFSET_BITS = 2, TAG_BITS constants.
  - Functions get_index, get_tag, word_align.
- Sub-module: dcache_wbuf (one-entry buffer with full flag), instantiated only under DCACHE_WRITE_BUFFER_EN. No other sub-module.

Test Plan:
- Reset mid-RD_WAIT, then a response arrives -> all outputs 0, state IDLE, response ignored, no fill_en.
- Load 0x0000_0104, cache_hit = 0, ready = 1, response 0xDEAD_BEEF two cycles later:
  - stall high for 4 cycles.
  - One-cycle fill_en with index 1, tag 0x0000008, data 0xDEADBEEF.
  - rdata_valid with 0xDEADBEEF.
- Load hit at 0x20 -> stall = 0, no mem_req_valid, no fill_en.
- Store 0x0000_0108 / 0x1234_5678 with hit, ready held low 3 cycles:
  - mem_req held stable, stall high for 4 cycles.
  - On handshake: fill_en with index 2, data 0x12345678.
- Store miss to 0x44 -> memory write issued, fill_en never asserted.
- Misaligned load 0x0000_0107, miss -> mem_req_addr = 0x0000_0104. With DCACHE_WRITE_BUFFER_EN: store then immediate load miss -> write request precedes read request.

Source files
------------

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared constants, FSM state encoding and address helpers for the
// D-cache miss controller. DCACHE_WRITE_BUFFER_EN adds the DRAIN state.
package dcache_pkg;

  localparam int ADDR_WIDTH  = 32;
  localparam int INDEX_BITS  = 3;
  localparam int OFFSET_BITS = 2;
  localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_FILL    = 3'd3,
    ST_WR_REQ  = 3'd4
`ifdef DCACHE_WRITE_BUFFER_EN
    , ST_DRAIN = 3'd5
`endif
  } state_e;

  function automatic logic [INDEX_BITS-1:0] get_index(input logic [ADDR_WIDTH-1:0] addr);
    return INDEX_BITS'(addr >> OFFSET_BITS);
  endfunction

  function automatic logic [TAG_BITS-1:0] get_tag(input logic [ADDR_WIDTH-1:0] addr);
    return TAG_BITS'(addr >> (INDEX_BITS + OFFSET_BITS));
  endfunction

  // Memory only ever sees word addresses.
  function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> OFFSET_BITS) << OFFSET_BITS;
  endfunction

endpackage

// File: rtl/dcache_wbuf.sv
// dcache_wbuf: single-entry posted store buffer (address, data, full flag),
// instantiated by dcache_miss_ctrl only when DCACHE_WRITE_BUFFER_EN is defined.
module dcache_wbuf #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] data
);

  logic                  full_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;

  // push only happens while empty and pop only while full, so they never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_reg <= 1'b0;
      addr_reg <= '0;
      data_reg <= '0;
    end else if (push) begin
      full_reg <= 1'b1;
      addr_reg <= push_addr;
      data_reg <= push_data;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign addr = addr_reg;
  assign data = data_reg;

endmodule

// File: rtl/dcache_miss_ctrl.sv
// dcache_miss_ctrl: load-miss refill and write-through store controller for a
// direct-mapped one-word-line D-cache. Define DCACHE_WRITE_BUFFER_EN for a posted store buffer.
module dcache_miss_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_valid,
  input  logic                  cpu_req_we,
  input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
  input  logic [DATA_WIDTH-1:0] cpu_req_wdata,
  input  logic                  cache_hit,
  output logic                  stall,
  output logic                  rdata_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  fill_en,
  output logic [INDEX_BITS-1:0] fill_index,
  output logic [TAG_BITS-1:0]   fill_tag,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_we,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data
);

  import dcache_pkg::*;

  localparam logic [2:0] S_IDLE    = ST_IDLE;
  localparam logic [2:0] S_RD_REQ  = ST_RD_REQ;
  localparam logic [2:0] S_RD_WAIT = ST_RD_WAIT;
  localparam logic [2:0] S_FILL    = ST_FILL;
  localparam logic [2:0] S_WR_REQ  = ST_WR_REQ;
`ifdef DCACHE_WRITE_BUFFER_EN
  localparam logic [2:0] S_DRAIN   = ST_DRAIN;
`endif

  logic [2:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [DATA_WIDTH-1:0] data_reg, data_next;
`ifndef DCACHE_WRITE_BUFFER_EN
  logic                  hit_reg, hit_next;
`endif

  logic load_miss, store_req;
  assign load_miss = cpu_req_valid && !cpu_req_we && !cache_hit;
  assign store_req = cpu_req_valid && cpu_req_we;

`ifdef DCACHE_WRITE_BUFFER_EN
  logic                  wb_push, wb_pop, wb_full;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;

  dcache_wbuf #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_wbuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wb_push),
    .push_addr (cpu_req_addr),
    .push_data (cpu_req_wdata),
    .pop       (wb_pop),
    .full      (wb_full),
    .addr      (wb_addr),
    .data      (wb_data)
  );
`endif

  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    data_next     = data_reg;
`ifndef DCACHE_WRITE_BUFFER_EN
    hit_next      = hit_reg;
`else
    wb_push       = 1'b0;
    wb_pop        = 1'b0;
`endif
    stall         = 1'b0;
    rdata_valid   = 1'b0;
    rdata         = '0;
    fill_en       = 1'b0;
    fill_index    = '0;
    fill_tag      = '0;
    fill_data     = '0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;

    case (state_reg)
      S_IDLE: begin
`ifdef DCACHE_WRITE_BUFFER_EN
        if (load_miss) begin
          stall      = 1'b1;
          addr_next  = cpu_req_addr;
          // an older posted store must reach memory before the refill read
          state_next = wb_full ? S_DRAIN : S_RD_REQ;
        end else if (store_req && !wb_full) begin
          wb_push = 1'b1;
          if (cache_hit) begin
            fill_en    = 1'b1;
            fill_index = get_index(cpu_req_addr);
            fill_tag   = get_tag(cpu_req_addr);
            fill_data  = cpu_req_wdata;
          end
        end else if (wb_full) begin
          stall      = store_req;
          state_next = S_WR_REQ;
        end
`else
        if (load_miss) begin
          stall      = 1'b1;
          addr_next  = cpu_req_addr;
          state_next = S_RD_REQ;
        end else if (store_req) begin
          stall      = 1'b1;
          addr_next  = cpu_req_addr;
          data_next  = cpu_req_wdata;
          hit_next   = cache_hit;
          state_next = S_WR_REQ;
        end
`endif
      end

      S_RD_REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = word_align(addr_reg);
        if (mem_req_ready) state_next = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        stall = 1'b1;
        if (mem_resp_valid) begin
          data_next  = mem_resp_data;
          state_next = S_FILL;
        end
      end

      S_FILL: begin
        fill_en     = 1'b1;
        fill_index  = get_index(addr_reg);
        fill_tag    = get_tag(addr_reg);
        fill_data   = data_reg;
        rdata_valid = 1'b1;
        rdata       = data_reg;
        state_next  = S_IDLE;
      end

      S_WR_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
`ifdef DCACHE_WRITE_BUFFER_EN
        mem_req_addr  = word_align(wb_addr);
        mem_req_wdata = wb_data;
        // draining in the background: only requests needing the FSM wait
        stall         = load_miss || store_req;
        if (mem_req_ready) begin
          wb_pop     = 1'b1;
          state_next = S_IDLE;
        end
`else
        mem_req_addr  = word_align(addr_reg);
        mem_req_wdata = data_reg;
        stall         = !mem_req_ready;
        if (mem_req_ready) begin
          if (hit_reg) begin
            fill_en    = 1'b1;
            fill_index = get_index(addr_reg);
            fill_tag   = get_tag(addr_reg);
            fill_data  = data_reg;
          end
          state_next = S_IDLE;
        end
`endif
      end

`ifdef DCACHE_WRITE_BUFFER_EN
      S_DRAIN: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = word_align(wb_addr);
        mem_req_wdata = wb_data;
        if (mem_req_ready) begin
          wb_pop     = 1'b1;
          state_next = S_RD_REQ;
        end
      end
`endif

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      addr_reg  <= '0;
      data_reg  <= '0;
`ifndef DCACHE_WRITE_BUFFER_EN
      hit_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
`ifndef DCACHE_WRITE_BUFFER_EN
      hit_reg   <= hit_next;
`endif
    end
  end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// tb_dcache_miss_ctrl: directed scoreboard bench for dcache_miss_ctrl; memory
// requests, fills and refill data are matched against queued expectations.
module tb_dcache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_we;
  logic [31:0] cpu_req_addr;
  logic [31:0] cpu_req_wdata;
  logic        cache_hit;
  logic        stall;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        fill_en;
  logic [2:0]  fill_index;
  logic [26:0] fill_tag;
  logic [31:0] fill_data;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_we;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  dcache_miss_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_wdata  (cpu_req_wdata),
    .cache_hit      (cache_hit),
    .stall          (stall),
    .rdata_valid    (rdata_valid),
    .rdata          (rdata),
    .fill_en        (fill_en),
    .fill_index     (fill_index),
    .fill_tag       (fill_tag),
    .fill_data      (fill_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_we     (mem_req_we),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct packed {
    logic [2:0]  idx;
    logic [26:0] tag;
    logic [31:0] data;
  } fill_exp_t;

  mem_exp_t    mem_q[$];
  fill_exp_t   fill_q[$];
  logic [31:0] rdata_q[$];

  int checks = 0;
  int errors = 0;
  int stall_cnt, fill_cnt, memv_cnt, rdv_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    mem_exp_t m;
    m.we = we; m.addr = addr; m.wdata = wdata;
    mem_q.push_back(m);
  endtask

  task automatic exp_fill(input logic [2:0] idx, input logic [26:0] tag, input logic [31:0] data);
    fill_exp_t f;
    f.idx = idx; f.tag = tag; f.data = data;
    fill_q.push_back(f);
  endtask

  task automatic clear_counts();
    stall_cnt = 0; fill_cnt = 0; memv_cnt = 0; rdv_cnt = 0;
  endtask

  // One clock: sample at the falling edge, score events, resume 1 after the rising edge.
  task automatic cycle();
    mem_exp_t    m;
    fill_exp_t   f;
    logic [31:0] r;
    @(negedge clk);
    if (stall) stall_cnt++;
    if (mem_req_valid) memv_cnt++;
    if (mem_req_valid && mem_req_ready) begin
      if (mem_q.size() == 0) chk("mem_unexpected", 1'b1, 1'b0);
      else begin
        m = mem_q.pop_front();
        $display("mem req: we=%0b addr=%08h wdata=%08h", mem_req_we, mem_req_addr, mem_req_wdata);
        chk("mem_we", mem_req_we, m.we);
        chk("mem_addr", mem_req_addr, m.addr);
        chk("mem_wdata", mem_req_wdata, m.wdata);
      end
    end
    if (fill_en) begin
      fill_cnt++;
      if (fill_q.size() == 0) chk("fill_unexpected", fill_en, 1'b0);
      else begin
        f = fill_q.pop_front();
        $display("fill: index=%0d tag=%07h data=%08h", fill_index, fill_tag, fill_data);
        chk("fill_index", fill_index, f.idx);
        chk("fill_tag", fill_tag, f.tag);
        chk("fill_data", fill_data, f.data);
      end
    end
    if (rdata_valid) begin
      rdv_cnt++;
      if (rdata_q.size() == 0) chk("rdata_unexpected", rdata_valid, 1'b0);
      else begin
        r = rdata_q.pop_front();
        $display("rdata: %08h", rdata);
        chk("rdata", rdata, r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0; cpu_req_addr = '0; cpu_req_wdata = '0;
    cache_hit = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    clear_counts();
    repeat (2) cycle();
    chk("rst_stall", stall, 1'b0);
    chk("rst_mem_valid", mem_req_valid, 1'b0);
    chk("rst_fill_en", fill_en, 1'b0);
    chk("rst_rdata_valid", rdata_valid, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_req_addr, 32'h0);
    rst_n = 1'b1;

    // Reset in the middle of RD_WAIT; the late response must be dropped.
    exp_mem(1'b0, 32'h0000_0200, 32'h0);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0200; cache_hit = 1'b0;
    mem_req_ready = 1'b1;
    repeat (3) cycle();
    rst_n = 1'b0; cpu_req_valid = 1'b0; mem_req_ready = 1'b0;
    #1;
    chk("midrst_stall", stall, 1'b0);
    chk("midrst_mem_valid", mem_req_valid, 1'b0);
    chk("midrst_fill_en", fill_en, 1'b0);
    chk("midrst_rdata_valid", rdata_valid, 1'b0);
    cycle();
    rst_n = 1'b1;
    clear_counts();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD_0BAD;
    cycle();
    mem_resp_valid = 1'b0;
    repeat (2) cycle();
    chk("stale_fill_cnt", fill_cnt, 0);
    chk("stale_rdv_cnt", rdv_cnt, 0);
    chk("stale_stall_cnt", stall_cnt, 0);
    chk("stale_memv_cnt", memv_cnt, 0);

    // Load miss at 0x104, response arrives one extra cycle into RD_WAIT.
    clear_counts();
    exp_mem(1'b0, 32'h0000_0104, 32'h0);
    exp_fill(3'd1, 27'h000_0008, 32'hDEAD_BEEF);
    rdata_q.push_back(32'hDEAD_BEEF);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0104; cache_hit = 1'b0;
    mem_req_ready = 1'b1;
    repeat (3) cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEAD_BEEF;
    cycle();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    cycle();
    cpu_req_valid = 1'b0; mem_req_ready = 1'b0;
    chk("ldmiss_stall_cycles", stall_cnt, 4);
    chk("ldmiss_fill_cnt", fill_cnt, 1);
    chk("ldmiss_rdv_cnt", rdv_cnt, 1);

    // Load hit at 0x20 with ready asserted: nothing happens.
    clear_counts();
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0020; cache_hit = 1'b1;
    mem_req_ready = 1'b1;
    repeat (2) cycle();
    cpu_req_valid = 1'b0; mem_req_ready = 1'b0;
    chk("ldhit_stall_cnt", stall_cnt, 0);
    chk("ldhit_memv_cnt", memv_cnt, 0);
    chk("ldhit_fill_cnt", fill_cnt, 0);

`ifdef DCACHE_WRITE_BUFFER_EN
    // Posted store then load miss: write must precede the refill read.
    clear_counts();
    exp_mem(1'b1, 32'h0000_0108, 32'h1234_5678);
    exp_mem(1'b0, 32'h0000_0300, 32'h0);
    exp_fill(3'd2, 27'h000_0008, 32'h1234_5678);
    exp_fill(3'd0, 27'h000_0018, 32'h5555_AAAA);
    rdata_q.push_back(32'h5555_AAAA);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 32'h0000_0108;
    cpu_req_wdata = 32'h1234_5678; cache_hit = 1'b1; mem_req_ready = 1'b1;
    cycle();
    chk("wb_store_stall", stall_cnt, 0);
    cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0300; cpu_req_wdata = '0; cache_hit = 1'b0;
    repeat (3) cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h5555_AAAA;
    cycle();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    cycle();
    cpu_req_valid = 1'b0; mem_req_ready = 1'b0;
    chk("wb_order_stall_cycles", stall_cnt, 4);
    chk("wb_order_fill_cnt", fill_cnt, 2);
    chk("wb_order_rdv_cnt", rdv_cnt, 1);
`else
    // Store hit at 0x108 with memory not ready for 3 cycles.
    clear_counts();
    exp_mem(1'b1, 32'h0000_0108, 32'h1234_5678);
    exp_fill(3'd2, 27'h000_0008, 32'h1234_5678);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 32'h0000_0108;
    cpu_req_wdata = 32'h1234_5678; cache_hit = 1'b1; mem_req_ready = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      chk("st_hold_valid", mem_req_valid, 1'b1);
      chk("st_hold_we", mem_req_we, 1'b1);
      chk("st_hold_addr", mem_req_addr, 32'h0000_0108);
      chk("st_hold_wdata", mem_req_wdata, 32'h1234_5678);
      cycle();
    end
    mem_req_ready = 1'b1;
    cycle();
    cpu_req_valid = 1'b0; mem_req_ready = 1'b0;
    chk("st_hit_stall_cycles", stall_cnt, 4);
    chk("st_hit_fill_cnt", fill_cnt, 1);
`endif

    // Store miss at 0x44: write goes out, cache is never written.
    clear_counts();
    exp_mem(1'b1, 32'h0000_0044, 32'hA5A5_0044);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b1; cpu_req_addr = 32'h0000_0044;
    cpu_req_wdata = 32'hA5A5_0044; cache_hit = 1'b0; mem_req_ready = 1'b1;
    cycle();
    cpu_req_valid = 1'b0; cpu_req_we = 1'b0;
    repeat (3) cycle();
    mem_req_ready = 1'b0;
    chk("st_miss_fill_cnt", fill_cnt, 0);
    chk("st_miss_mem_done", mem_q.size(), 0);
`ifdef DCACHE_WRITE_BUFFER_EN
    chk("st_miss_stall_cycles", stall_cnt, 0);
`else
    chk("st_miss_stall_cycles", stall_cnt, 1);
`endif

    // Misaligned load miss: byte offset is stripped, minimum-latency response.
    clear_counts();
    exp_mem(1'b0, 32'h0000_0104, 32'h0);
    exp_fill(3'd1, 27'h000_0008, 32'hCAFE_F00D);
    rdata_q.push_back(32'hCAFE_F00D);
    cpu_req_valid = 1'b1; cpu_req_we = 1'b0; cpu_req_addr = 32'h0000_0107; cache_hit = 1'b0;
    mem_req_ready = 1'b1;
    repeat (2) cycle();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hCAFE_F00D;
    cycle();
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    cycle();
    cpu_req_valid = 1'b0; mem_req_ready = 1'b0;
    chk("misalign_stall_cycles", stall_cnt, 3);
    chk("misalign_rdv_cnt", rdv_cnt, 1);

    repeat (2) cycle();
    chk("mem_q_drained", mem_q.size(), 0);
    chk("fill_q_drained", fill_q.size(), 0);
    chk("rdata_q_drained", rdata_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
